clk_switch_ctrl: RTL and testbench

- Control stage directly upstream of the clock multiplexer and enable-gating stage.
- Produces the `sel` and `en` signals that stage consumes.
- Sequences every source change as: gate the output clock off, wait, flip the select, wait, restore the gate.
- This keeps the mux free of glitches.
- Runs on a single control clock. Request inputs may be asynchronous, so they are synchronized internally.

---
 rtl/clk_switch_ctrl_pkg.sv | 17 +
 rtl/clk_switch_ctrl_sync_ff.sv | 20 ++
 rtl/clk_switch_ctrl.sv | 110 +++++++++++
 tb/tb_clk_switch_ctrl.sv | 191 +++++++++++++++++++
 4 files changed

// File: rtl/clk_switch_ctrl_pkg.sv
// Shared types and limits for the glitch-free clock switch controller.
package clk_switch_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_GATE_OFF = 2'd1,
    ST_SWITCH   = 2'd2
  } state_t;

  localparam int unsigned SYNC_STAGES_MIN = 2;
  localparam int unsigned WAIT_MIN        = 1;

  function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/clk_switch_ctrl_sync_ff.sv
// Single-bit multi-flop synchronizer with synchronous active-high clear.
module sync_ff #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic i_d,
  output logic o_q
);

  logic [SYNC_STAGES-1:0] r_chain;

  always_ff @(posedge clk) begin
    if (rst) r_chain <= '0;
    else     r_chain <= {r_chain[SYNC_STAGES-2:0], i_d};
  end

  assign o_q = r_chain[SYNC_STAGES-1];

endmodule

// File: rtl/clk_switch_ctrl.sv
// Sequences clock-source changes as gate off, wait, flip select, wait, re-enable,
// so the downstream mux never sees a select change while its output is gated on.
module clk_switch_ctrl
  import clk_switch_ctrl_pkg::*;
#(
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned GATE_WAIT   = 4,
  parameter int unsigned SEL_WAIT    = 3,
  parameter logic        SEL_RST     = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic sel_req,
  input  logic en_req,
  output logic sel,
  output logic en,
  output logic busy,
  output logic done
);

  localparam int unsigned CNT_W = $clog2(max_u(GATE_WAIT, SEL_WAIT)) + 1;
  localparam logic [CNT_W-1:0] GATE_LAST = CNT_W'(GATE_WAIT - 1);
  localparam logic [CNT_W-1:0] SEL_LAST  = CNT_W'(SEL_WAIT - 1);

  if (SYNC_STAGES < SYNC_STAGES_MIN) begin : g_bad_sync
    $error("SYNC_STAGES below legal minimum");
  end
  if (GATE_WAIT < WAIT_MIN || SEL_WAIT < WAIT_MIN) begin : g_bad_wait
    $error("wait parameters below legal minimum");
  end

  logic             w_sel_s;
  logic             w_en_s;
  state_t           r_state;
  logic [CNT_W-1:0] r_cnt;
  logic             r_sel;
  logic             r_en;
  logic             r_busy;
  logic             r_done;

  sync_ff #(.SYNC_STAGES(SYNC_STAGES)) u_sync_sel (
    .clk (clk),
    .rst (rst),
    .i_d (sel_req),
    .o_q (w_sel_s)
  );

  sync_ff #(.SYNC_STAGES(SYNC_STAGES)) u_sync_en (
    .clk (clk),
    .rst (rst),
    .i_d (en_req),
    .o_q (w_en_s)
  );

  // Switch sequencer; en stays low for the whole GATE_OFF/SWITCH span.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
      r_sel   <= SEL_RST;
      r_en    <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_sel_s != r_sel) begin
            r_state <= ST_GATE_OFF;
            r_en    <= 1'b0;
            r_busy  <= 1'b1;
            r_cnt   <= '0;
          end else begin
            r_en <= w_en_s;
          end
        end
        ST_GATE_OFF: begin
          if (r_cnt == GATE_LAST) begin
            r_state <= ST_SWITCH;
            r_sel   <= ~r_sel;
            r_cnt   <= '0;
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        ST_SWITCH: begin
          if (r_cnt == SEL_LAST) begin
            r_state <= ST_IDLE;
            r_en    <= w_en_s;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
            r_cnt   <= '0;
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        default: begin
          r_state <= ST_IDLE;
          r_cnt   <= '0;
        end
      endcase
    end
  end

  assign sel  = r_sel;
  assign en   = r_en;
  assign busy = r_busy;
  assign done = r_done;

endmodule

// File: tb/tb_clk_switch_ctrl.sv
// Self-checking bench: directed scenarios plus random traffic against a timeline model.
module tb_clk_switch_ctrl;

  localparam int unsigned SYNC = 2;
  localparam int unsigned GW   = 4;
  localparam int unsigned SW   = 3;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic sel_req = 1'b0;
  logic en_req = 1'b0;
  logic sel, en, busy, done;

  int n_cmp = 0;
  int n_err = 0;

  bit h_sel [SYNC];
  bit h_en  [SYNC];
  bit m_sel, m_en, m_busy, m_done;
  int m_k;
  logic last_sel, last_en;

  always #5 clk = ~clk;

  clk_switch_ctrl #(
    .SYNC_STAGES (SYNC),
    .GATE_WAIT   (GW),
    .SEL_WAIT    (SW),
    .SEL_RST     (1'b0)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .sel_req (sel_req),
    .en_req  (en_req),
    .sel     (sel),
    .en      (en),
    .busy    (busy),
    .done    (done)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // One control edge: drive inputs, advance the model, compare all outputs.
  task automatic step(input bit s, input bit e, input bit r);
    bit sel_s, en_s;
    @(negedge clk);
    sel_req = s;
    en_req  = e;
    rst     = r;
    last_sel = sel;
    last_en  = en;
    @(posedge clk);
    sel_s = h_sel[SYNC-1];
    en_s  = h_en[SYNC-1];
    if (r) begin
      for (int i = 0; i < SYNC; i++) begin
        h_sel[i] = 1'b0;
        h_en[i]  = 1'b0;
      end
      m_sel = 1'b0; m_en = 1'b0; m_busy = 1'b0; m_done = 1'b0; m_k = 0;
    end else begin
      for (int i = SYNC - 1; i > 0; i--) begin
        h_sel[i] = h_sel[i-1];
        h_en[i]  = h_en[i-1];
      end
      h_sel[0] = s;
      h_en[0]  = e;
      m_done = 1'b0;
      if (!m_busy) begin
        if (sel_s != m_sel) begin
          m_busy = 1'b1;
          m_en   = 1'b0;
          m_k    = 0;
        end else begin
          m_en = en_s;
        end
      end else begin
        m_k++;
        if (m_k == GW) m_sel = ~m_sel;
        if (m_k == GW + SW) begin
          m_busy = 1'b0;
          m_en   = en_s;
          m_done = 1'b1;
        end
      end
    end
    #1;
    chk("sel",  32'(sel),  32'(m_sel));
    chk("en",   32'(en),   32'(m_en));
    chk("busy", 32'(busy), 32'(m_busy));
    chk("done", 32'(done), 32'(m_done));
    if (!r && last_sel !== sel) chk("sel_moved_with_en", 32'({last_en, en}), 32'd0);
  endtask

  initial begin
    bit s_cur, e_cur, r_cur;

    // Reset held two edges with arbitrary inputs
    for (int i = 0; i < 2; i++) begin
      step(1'($urandom), 1'($urandom), 1'b1);
      chk("rst_sel", 32'(sel), 32'd0);
      chk("rst_en", 32'(en), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_done", 32'(done), 32'd0);
    end
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b0);

    // Enable pass-through, rise then fall
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 1'b1, 1'b0);
      chk("pass_rise", 32'(en), (i == 2) ? 32'd1 : 32'd0);
      chk("pass_busy", 32'(busy), 32'd0);
    end
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 1'b0, 1'b0);
      chk("pass_fall", 32'(en), (i == 2) ? 32'd0 : 32'd1);
    end
    for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 1'b0);

    // Clean switch 0 -> 1 with enable on
    for (int i = 0; i < 11; i++) begin
      step(1'b1, 1'b1, 1'b0);
      if (i == 2) begin
        chk("sw_en_off", 32'(en), 32'd0);
        chk("sw_busy_on", 32'(busy), 32'd1);
      end
      if (i == 5) chk("sw_sel_pre", 32'(sel), 32'd0);
      if (i == 6) chk("sw_sel_post", 32'(sel), 32'd1);
      if (i == 9) begin
        chk("sw_en_back", 32'(en), 32'd1);
        chk("sw_busy_off", 32'(busy), 32'd0);
        chk("sw_done", 32'(done), 32'd1);
      end
      if (i == 10) chk("sw_done_clr", 32'(done), 32'd0);
    end

    // Request reverted while busy: two back-to-back sequences
    for (int i = 0; i < 20; i++) begin
      step((i < 4) ? 1'b0 : 1'b1, 1'b1, 1'b0);
      if (i == 9) begin
        chk("rev_sel_first", 32'(sel), 32'd0);
        chk("rev_done_first", 32'(done), 32'd1);
      end
      if (i == 10) chk("rev_restart", 32'(busy), 32'd1);
      if (i == 14) chk("rev_sel_second", 32'(sel), 32'd1);
      if (i == 17) chk("rev_done_second", 32'(done), 32'd1);
    end

    // Enable request dropped during SWITCH
    for (int i = 0; i < 12; i++) begin
      step(1'b0, (i < 6) ? 1'b1 : 1'b0, 1'b0);
      if (i == 9) begin
        chk("drop_en", 32'(en), 32'd0);
        chk("drop_done", 32'(done), 32'd1);
      end
    end

    // Reset during GATE_OFF with cnt=2
    for (int i = 0; i < 17; i++) begin
      step(1'b1, 1'b1, (i == 5) ? 1'b1 : 1'b0);
      if (i == 5) begin
        chk("mid_rst_sel", 32'(sel), 32'd0);
        chk("mid_rst_en", 32'(en), 32'd0);
        chk("mid_rst_busy", 32'(busy), 32'd0);
        chk("mid_rst_done", 32'(done), 32'd0);
      end
      if (i == 7) chk("mid_rst_idle", 32'(busy), 32'd0);
      if (i == 8) chk("mid_rst_restart", 32'(busy), 32'd1);
    end

    // Random traffic
    s_cur = sel_req;
    e_cur = en_req;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 11) == 0) s_cur = ~s_cur;
      if ($urandom_range(0, 5) == 0) e_cur = ~e_cur;
      r_cur = ($urandom_range(0, 299) == 0);
      step(s_cur, e_cur, r_cur);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
